shift_register_with_valid_ready: RTL and testbench

Parametrised elastic shift register. Each stage carries a data word and a valid bit, with a full valid/ready handshake on both ends. A stage advances whenever its downstream neighbour can take it, so empty stages (bubbles) are collapsed and the block supports backpressure. It sits between pipelined arithmetic stages where a producer and consumer must be decoupled by a fixed number of register slots.

---
 rtl/shift_register_with_valid_ready.sv | 89 ++++++++
 tb/tb_shift_register_with_valid_ready.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_with_valid_ready.sv
// Elastic valid/ready shift register: `depth` stages that collapse bubbles and honour backpressure.
// Optional synchronous flush input enabled by defining SHIFT_REGISTER_FLUSH_EN.
module shift_register_with_valid_ready #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef SHIFT_REGISTER_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [width-1:0]             in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [width-1:0]             out_data,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int CW = $clog2(depth + 1);

    logic [depth-1:0] r_v;
    logic [width-1:0] r_d [depth];
    logic [CW-1:0]    r_cnt;

    logic [depth-1:0] w_acc;
    logic             w_flush;
    logic             w_in_xfer;
    logic             w_out_xfer;

`ifdef SHIFT_REGISTER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A stage can load when it is empty or the stage after it is moving.
    always_comb begin
        logic [depth-1:0] acc_v;
        acc_v            = '0;
        acc_v[depth-1]   = !r_v[depth-1] || out_rdy;
        for (int i = depth - 2; i >= 0; i--) begin
            acc_v[i] = !r_v[i] || acc_v[i+1];
        end
        w_acc = acc_v;
    end

    assign in_rdy     = w_acc[0] && !w_flush;
    assign out_vld    = r_v[depth-1] && !w_flush;
    assign out_data   = r_d[depth-1];
    assign count      = r_cnt;
    assign w_in_xfer  = in_vld && in_rdy;
    assign w_out_xfer = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            r_v   <= '0;
            r_cnt <= '0;
        end else begin
            if (w_acc[0]) begin
                r_v[0] <= in_vld;
            end
            for (int i = 1; i < depth; i++) begin
                if (w_acc[i]) begin
                    r_v[i] <= r_v[i-1];
                end
            end
            case ({w_in_xfer, w_out_xfer})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Data carries no reset; it only loads behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_acc[0] && in_vld) begin
            r_d[0] <= in_data;
        end
        for (int i = 1; i < depth; i++) begin
            if (w_acc[i] && r_v[i-1]) begin
                r_d[i] <= r_d[i-1];
            end
        end
    end

endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// Directed self-checking bench for shift_register_with_valid_ready (width 8, depth 8).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_shift_register_with_valid_ready;

    localparam int W = 8;
    localparam int D = 8;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] out_data;
    logic [3:0]   count;

    int checks;
    int errors;

    shift_register_with_valid_ready #(.width(W), .depth(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SHIFT_REGISTER_FLUSH_EN
        .flush    (flush),
`endif
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = 'x;
        out_rdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        checks++;
        if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_idle_out_vld cyc %0d got %b want 0", n, out_vld); end
        end
        in_data = '0;
    endtask

    // Word w (1..32) is accepted at edge w-1 and appears before edge w+7.
    task automatic test_streaming();
        int exp_cnt;
        int acc;
        int del;
        out_rdy = 1'b1;
        for (int n = 0; n < 44; n++) begin
            if (n < 32) begin
                in_vld  = 1'b1;
                in_data = W'(n + 1);
            end else begin
                in_vld  = 1'b0;
                in_data = '0;
            end
            #1;
            acc = (n < 32) ? n : 32;
            del = (n - 8 < 0) ? 0 : ((n - 8 > 32) ? 32 : n - 8);
            exp_cnt = acc - del;
            if (n - 7 >= 1 && n - 7 <= 32) begin
                checks++;
                if (out_vld !== 1'b1 || out_data !== W'(n - 7)) begin
                    errors++;
                    $display("FAIL stream_out cyc %0d got vld=%b data=%h want vld=1 data=%h", n, out_vld, out_data, W'(n - 7));
                end
            end else begin
                checks++;
                if (out_vld !== 1'b0) begin errors++; $display("FAIL stream_idle cyc %0d got vld=%b want 0", n, out_vld); end
            end
            checks++;
            if (count !== 4'(exp_cnt)) begin errors++; $display("FAIL stream_count cyc %0d got %0d want %0d", n, count, exp_cnt); end
            if (n < 32) begin
                checks++;
                if (in_rdy !== 1'b1) begin errors++; $display("FAIL stream_in_rdy cyc %0d got %b want 1", n, in_rdy); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            in_vld  = 1'b1;
            in_data = W'(j);
            #1;
            checks++;
            if (in_rdy !== (j <= 8)) begin errors++; $display("FAIL bp_in_rdy offer %0d got %b want %b", j, in_rdy, (j <= 8)); end
            tick();
        end
        in_vld = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (count !== 4'd8) begin errors++; $display("FAIL bp_count got %0d want 8", count); end
            checks++;
            if (out_vld !== 1'b1 || out_data !== 8'h01) begin
                errors++; $display("FAIL bp_stall_out got vld=%b data=%h want vld=1 data=01", out_vld, out_data);
            end
            tick();
        end
        out_rdy = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            #1;
            checks++;
            if (out_vld !== 1'b1 || out_data !== W'(e)) begin
                errors++; $display("FAIL bp_drain got vld=%b data=%h want vld=1 data=%h", out_vld, out_data, W'(e));
            end
            tick();
        end
        checks++;
        if (out_vld !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL bp_empty got vld=%b count=%0d want vld=0 count=0", out_vld, count);
        end
    endtask

    task automatic test_bubble();
        out_rdy = 1'b0;
        in_vld  = 1'b1; in_data = 8'hA5; tick();
        in_vld  = 1'b0; in_data = 8'h00; tick(); tick(); tick();
        in_vld  = 1'b1; in_data = 8'h5A; tick();
        in_vld  = 1'b0; in_data = 8'h00;
        for (int n = 0; n < 8; n++) tick();
        checks++;
        if (count !== 4'd2) begin errors++; $display("FAIL bubble_count got %0d want 2", count); end
        checks++;
        if (out_vld !== 1'b1 || out_data !== 8'hA5) begin
            errors++; $display("FAIL bubble_head got vld=%b data=%h want vld=1 data=a5", out_vld, out_data);
        end
        out_rdy = 1'b1;
        tick();
        checks++;
        if (out_vld !== 1'b1 || out_data !== 8'h5A) begin
            errors++; $display("FAIL bubble_second got vld=%b data=%h want vld=1 data=5a", out_vld, out_data);
        end
        tick();
        checks++;
        if (out_vld !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL bubble_empty got vld=%b count=%0d want vld=0 count=0", out_vld, count);
        end
    endtask

    task automatic test_full_simul();
        out_rdy = 1'b0;
        for (int j = 0; j < 8; j++) begin
            in_vld = 1'b1; in_data = W'(8'h11 + j); tick();
        end
        in_vld = 1'b0;
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", count); end
        out_rdy = 1'b1; in_vld = 1'b1; in_data = 8'hEE;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL full_in_rdy got %b want 1", in_rdy); end
        tick();
        in_vld = 1'b0; in_data = 8'h00;
        #1;
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL full_simul_count got %0d want 8", count); end
        for (int e = 0; e < 8; e++) begin
            logic [W-1:0] exp;
            exp = (e < 7) ? W'(8'h12 + e) : 8'hEE;
            checks++;
            if (out_vld !== 1'b1 || out_data !== exp) begin
                errors++; $display("FAIL full_drain got vld=%b data=%h want vld=1 data=%h", out_vld, out_data, exp);
            end
            tick();
        end
        checks++;
        if (out_vld !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL full_empty got vld=%b count=%0d want vld=0 count=0", out_vld, count);
        end
    endtask

    task automatic test_midop_clear();
        out_rdy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            in_vld = 1'b1; in_data = W'(8'h31 + j); tick();
        end
        in_vld = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL clear_pre_count got %0d want 5", count); end
        out_rdy = 1'b1;
`ifdef SHIFT_REGISTER_FLUSH_EN
        flush = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got in_rdy=%b out_vld=%b want 0 0", in_rdy, out_vld);
        end
        tick();
        flush = 1'b0;
`else
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`endif
        #1;
        checks++;
        if (count !== 4'd0 || out_vld !== 1'b0) begin
            errors++; $display("FAIL clear_after got count=%0d vld=%b want 0 0", count, out_vld);
        end
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (out_vld !== 1'b0) begin errors++; $display("FAIL clear_leak cyc %0d got vld=%b data=%h want 0", n, out_vld, out_data); end
        end
        checks++;
        if (in_rdy !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL clear_idle got in_rdy=%b count=%0d want 1 0", in_rdy, count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_full_simul();
        test_midop_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
